rng_req_sched: RTL and testbench

//  Controller that shares a single RNG core (4-bit seed, 2-bit mode, 8-bit output)

---
 rtl/rng_req_sched_if.sv | 32 +++
 rtl/rng_req_sched.sv | 177 +++++++++++++++++
 tb/tb_rng_req_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_req_sched_if.sv
// Signal bundle for rng_req_sched: requester side, response handshake and RNG core strobes.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface rng_req_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic                ena;
    logic [3:0]          seed_in;
    logic                seed_load;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_mode;
    logic [NREQ-1:0]     gnt;
    logic                core_load;
    logic [3:0]          core_seed;
    logic [1:0]          core_mode;
    logic                core_step;
    logic [7:0]          core_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_data;

    modport slave (
        input  ena, seed_in, seed_load, req, req_mode, core_data, rsp_ready,
        output gnt, core_load, core_seed, core_mode, core_step, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output ena, seed_in, seed_load, req, req_mode, core_data, rsp_ready,
        input  gnt, core_load, core_seed, core_mode, core_step, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rng_req_sched.sv
// Round-robin scheduler sharing one RNG core between NREQ requesters.
// Optional RNG_RESEED_EN: automatic reseed after every RESEED deliveries.
//
// state     | meaning
// IDLE      | service pending seed load first, else grant next requester
// LOAD      | one-cycle core_load with the stored seed
// RUN       | WARMUP core_step cycles in the granted requester's mode
// CAPTURE   | register core_data into the response
// DELIVER   | hold response until rsp_ready
module rng_req_sched #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 4,
    parameter int RESEED = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rng_req_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [3:0]      seed_q, seed_d;
    logic            pend_q, pend_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [1:0]      mode_q, mode_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  pick;
    logic [1:0]      pick_mode;
    logic [NREQ-1:0] gnt;
    logic            hs;
`ifdef RNG_RESEED_EN
    logic [7:0]      dcnt_q, dcnt_d;
    logic [3:0]      wrap_q, wrap_d;
`endif

    // An all-zero seed would lock an LFSR core, so it is bumped to 1.
    function automatic logic [3:0] seed_guard(input logic [3:0] s);
        return (s == 4'h0) ? 4'h1 : s;
    endfunction

    always_comb begin : rr_pick
        int idx;
        idx  = 0;
        pick = rr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[idx]) pick = IDW'(idx);
        end
        pick_mode = bus.req_mode[{pick, 1'b0} +: 2];
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        pend_d      = pend_q;
        rr_d        = rr_q;
        id_d        = id_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        gnt         = '0;
        hs          = (state_q == S_DELIVER) && rsp_valid_q && bus.rsp_ready;
`ifdef RNG_RESEED_EN
        dcnt_d      = dcnt_q;
        wrap_d      = wrap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_LOAD;
                end else if (bus.ena && (|bus.req)) begin
                    gnt     = NREQ'(1) << pick;
                    id_d    = pick;
                    mode_d  = (pick_mode == 2'b11) ? 2'b00 : pick_mode;
                    cnt_d   = 4'(WARMUP);
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
`ifdef RNG_RESEED_EN
                dcnt_d  = '0;
`endif
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_data_d  = bus.core_data;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_DELIVER;
            end
            S_DELIVER: begin
                if (hs) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef RNG_RESEED_EN
        if (hs) begin
            dcnt_d = dcnt_q + 8'd1;
            if (dcnt_d == 8'(RESEED)) begin
                wrap_d = wrap_q + 4'd1;
                seed_d = seed_guard(seed_q ^ wrap_d);
                pend_d = 1'b1;
            end
        end
`endif
        // An external seed always wins, including over a same-cycle LOAD clear.
        if (bus.seed_load) begin
            seed_d = seed_guard(bus.seed_in);
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seed_q      <= 4'hA;
            pend_q      <= 1'b1;
            rr_q        <= '0;
            id_q        <= '0;
            mode_q      <= 2'b00;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 8'h00;
`ifdef RNG_RESEED_EN
            dcnt_q      <= 8'h00;
            wrap_q      <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RNG_RESEED_EN
            dcnt_q      <= dcnt_d;
            wrap_q      <= wrap_d;
`endif
        end
    end

    assign bus.gnt       = gnt;
    assign bus.core_load = (state_q == S_LOAD);
    assign bus.core_seed = seed_q;
    assign bus.core_step = (state_q == S_RUN);
    assign bus.core_mode = (state_q == S_RUN) ? mode_q : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_rng_req_sched.sv
// Randomized scoreboard bench for rng_req_sched with a behavioural RNG core and reference model.
module tb_rng_req_sched;
    localparam int NREQ   = 4;
    localparam int WARMUP = 4;
    localparam int RESEED = 16;
    localparam int IDW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rng_req_sched_if #(.NREQ(NREQ)) bus();
    rng_req_sched #(.NREQ(NREQ), .WARMUP(WARMUP), .RESEED(RESEED)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     mode;
        logic [7:0]     data;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;
    txn_t gq[$];
    logic [3:0] lq[$];

    int         ptr    = 0;
    logic [3:0] m_seed = 4'hA;
    bit         m_pend = 1'b1;
    logic [7:0] m_core = 8'h00;
    int         m_cnt  = 0;
    int         m_wrap = 0;

    function automatic logic [7:0] core_next(input logic [7:0] s, input logic [1:0] m);
        case (m)
            2'd0:    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
            2'd1:    return s * 8'd5 + 8'd1;
            2'd2:    return {s[0], s[7:1]} ^ 8'h1D;
            default: return ~s;
        endcase
    endfunction

    function automatic logic [3:0] guard4(input logic [3:0] s);
        return (s == 4'h0) ? 4'h1 : s;
    endfunction

    // Environment RNG core, driven only by the scheduler's strobes.
    logic [7:0] core_q = 8'h00;
    always @(posedge clk) begin
        if (bus.core_load)      core_q <= {bus.core_seed, ~bus.core_seed};
        else if (bus.core_step) core_q <= core_next(core_q, bus.core_mode);
    end
    assign bus.core_data = core_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pending seed is loaded before the draw, then round-robin pick and WARMUP steps.
    task automatic issue(input logic [NREQ-1:0] pat, input logic [2*NREQ-1:0] modes);
        txn_t t;
        int id;
        logic [1:0] raw;
        if (m_pend) begin
            lq.push_back(m_seed);
            m_core = {m_seed, ~m_seed};
            m_pend = 1'b0;
            m_cnt  = 0;
        end
        id = -1;
        for (int k = 0; k < NREQ; k++)
            if (id < 0 && pat[(ptr + k) % NREQ]) id = (ptr + k) % NREQ;
        raw    = modes[2*id +: 2];
        t.id   = IDW'(id);
        t.mode = (raw == 2'b11) ? 2'b00 : raw;
        for (int s = 0; s < WARMUP; s++) m_core = core_next(m_core, t.mode);
        t.data = m_core;
        gq.push_back(t);
        ptr = (id + 1) % NREQ;
    endtask

    int gnt_cnt = 0;
    int hs_cnt  = 0;
    bit in_txn = 1'b0, pv = 1'b0, phs = 1'b0, mode_ok = 1'b1;
    int lat = 0, steps = 0;
    txn_t cur;
    logic [7:0]     pdata = 8'h00;
    logic [IDW-1:0] pid   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
            pv     = 1'b0;
            phs    = 1'b0;
        end else begin
            if (!bus.ena) chk("gnt_ena_low", 32'(bus.gnt), 32'd0);
            if (bus.core_load) begin
                if (lq.size() == 0) chk("load_unexpected", 32'(bus.core_load), 32'd0);
                else chk("load_seed", 32'(bus.core_seed), 32'(lq.pop_front()));
                chk("load_quiet", 32'({bus.gnt, bus.core_step, bus.core_mode, bus.rsp_valid}), 32'd0);
            end
            if (bus.gnt != '0) begin
                if (in_txn || gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
                else begin
                    cur = gq.pop_front();
                    chk("gnt_onehot", 32'(bus.gnt), 32'd1 << cur.id);
                    in_txn = 1'b1; lat = 0; steps = 0; mode_ok = 1'b1;
                    gnt_cnt++;
                end
            end else if (in_txn) begin
                lat++;
                if (bus.core_step) begin
                    steps++;
                    if (bus.core_mode !== cur.mode) mode_ok = 1'b0;
                end
            end else if (bus.core_step) chk("step_idle", 32'(bus.core_step), 32'd0);
            if (bus.rsp_valid && !pv) begin
                if (!in_txn) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'(in_txn));
                else begin
                    chk("latency", 32'(lat), 32'(WARMUP + 2));
                    chk("step_count", 32'(steps), 32'(WARMUP));
                    chk("run_mode", 32'(mode_ok), 32'd1);
                end
            end
            if (bus.rsp_valid) chk("gnt_in_deliver", 32'(bus.gnt), 32'd0);
            if (pv && !phs) chk("hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 32'({1'b1, pid, pdata}));
            phs = bus.rsp_valid && bus.rsp_ready;
            if (phs) begin
                if (in_txn) begin
                    chk("rsp_id", 32'(bus.rsp_id), 32'(cur.id));
                    chk("rsp_data", 32'(bus.rsp_data), 32'(cur.data));
                end
                in_txn = 1'b0;
                hs_cnt++;
            end
            pv    = bus.rsp_valid;
            pid   = bus.rsp_id;
            pdata = bus.rsp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_seed(input logic [3:0] s);
        bus.seed_in   = s;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        m_seed = guard4(s);
        m_pend = 1'b1;
    endtask

    task automatic wait_gnt(input int g0);
        int n = 0;
        while (gnt_cnt == g0 && n < 100) begin tick(); n++; end
        if (gnt_cnt == g0) chk("gnt_timeout", 32'(gnt_cnt), 32'(g0 + 1));
    endtask

    task automatic wait_hs(input int h0, input bit stall);
        int n = 0, sc = 0;
        while (hs_cnt == h0 && n < 200) begin
            if (stall && sc < 10) begin
                bus.rsp_ready = 1'b0;
                if (bus.rsp_valid) sc++;
            end else bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (hs_cnt == h0) chk("hs_timeout", 32'(hs_cnt), 32'(h0 + 1));
        bus.rsp_ready = 1'b0;
`ifdef RNG_RESEED_EN
        m_cnt++;
        if (m_cnt == RESEED) begin
            m_wrap = (m_wrap + 1) % 16;
            m_seed = guard4(m_seed ^ 4'(m_wrap));
            m_pend = 1'b1;
        end
`endif
    endtask

    task automatic round(input logic [NREQ-1:0] pat, input logic [2*NREQ-1:0] modes,
                         input bit ena_low, input bit drop, input bit stall,
                         input int mid_pulses, input logic [3:0] mseed);
        int g0, h0;
        bit pre;
        g0  = gnt_cnt;
        h0  = hs_cnt;
        pre = !m_pend && !ena_low && ($urandom_range(0, 3) == 0);
        issue(pat, modes);
        bus.req_mode = modes;
        bus.req      = pat;
        bus.ena      = !ena_low;
        if (pre) pulse_seed(4'($urandom_range(0, 15)));
        if (ena_low) begin
            repeat (4) tick();
            bus.ena = 1'b1;
        end
        wait_gnt(g0);
        if (drop) bus.req = '0;
        if (mid_pulses > 0) begin
            repeat ($urandom_range(0, 1)) tick();
            pulse_seed(mseed);
            for (int i = 1; i < mid_pulses; i++) pulse_seed(4'($urandom_range(0, 15)));
        end
        wait_hs(h0, stall);
    endtask

    initial begin
        int g0;
        bus.ena = 1'b1; bus.seed_in = 4'h0; bus.seed_load = 1'b0;
        bus.req = '0; bus.req_mode = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_core", 32'({bus.core_load, bus.core_step, bus.core_mode}), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 32'd0);
        chk("rst_seed", 32'(bus.core_seed), 32'hA);
        rst_n = 1'b1;

        round(4'b0001, 8'b01, 1'b0, 1'b1, 1'b0, 0, 4'h0);
        repeat (5) round(4'b1111, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, 4'h0);
        round(4'b0110, 8'($urandom), 1'b0, 1'b0, 1'b1, 0, 4'h0);
        round(4'b1010, 8'($urandom), 1'b0, 1'b1, 1'b0, 1, 4'h0);
        round(4'b1111, 8'($urandom), 1'b1, 1'b0, 1'b0, 0, 4'h0);
        round(4'b0101, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 4'h3);
        for (int r = 0; r < 40; r++)
            round(4'($urandom_range(1, 15)), 8'($urandom), ($urandom_range(0, 5) == 0),
                  1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                  4'($urandom_range(0, 15)));

        g0 = gnt_cnt;
        issue(4'b0100, 8'($urandom));
        bus.req = 4'b0100;
        bus.ena = 1'b1;
        wait_gnt(g0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_run_step", 32'(bus.core_step), 32'd0);
        chk("rst_run_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_run_seed", 32'(bus.core_seed), 32'hA);
        gq.delete(); lq.delete();
        ptr = 0; m_seed = 4'hA; m_pend = 1'b1; m_cnt = 0; m_wrap = 0;
        bus.req = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) round(4'b1111, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, 4'h0);

        if (m_pend) begin
            lq.push_back(m_seed);
            m_pend = 1'b0;
        end
        bus.req = '0;
        repeat (10) tick();
        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("lq_empty", 32'(lq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
